// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: controller state encoding
// and the default operand width.
package sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Controller states; the 2-bit encoding is visible on waveforms and fixed.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: X - Y - Bin, producing difference D and borrow Bout.
module full_subtractor (
    input  logic X,
    input  logic Y,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    // Difference bit and borrow out of this bit position.
    assign D    = X ^ Y ^ Bin;
    assign Bout = (~X & Y) | (~(X ^ Y) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes (A - B) mod 2^WIDTH one bit per clock,
// LSB first, with a final borrow that flags A < B (unsigned).
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic             brw;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             bit_diff;
    logic             bit_brw;

    // A start is only honoured when no subtraction is in flight.
    assign accept = start && (state != RUN);

    full_subtractor u_fs (
        .X    (a_sh[0]),
        .Y    (b_sh[0]),
        .Bin  (brw),
        .D    (bit_diff),
        .Bout (bit_brw)
    );

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking in clocked blocks so every flop samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: RUN lasts exactly WIDTH cycles; DONE may chain straight into RUN.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST_BIT) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state alone, so busy and done are exclusive.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: load on accept, then shift operands right and the result in from the MSB.
    always_ff @(posedge clk) begin
        // NOTE: every datapath flop is reset; D and Bout are outputs that must read 0 after reset.
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            d_sh <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
        end else if (accept) begin
            a_sh <= A;
            b_sh <= B;
            d_sh <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
            d_sh <= {bit_diff, d_sh[WIDTH-1:1]};
            brw  <= bit_brw;
            cnt  <= cnt + CNT_ONE;
        end
    end

    // The borrow flop is frozen outside RUN, so after the last bit it is the final borrow.
    assign D    = d_sh;
    assign Bout = brw;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin a subtraction.
REQ-005 SHALL have port A, input, WIDTH, minuend; sampled only on an accepted start.
REQ-006 SHALL have port B, input, WIDTH, subtrahend; sampled only on an accepted start.
REQ-007 SHALL have port busy, output, 1, high while in RUN.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking a valid result.
REQ-009 SHALL have port D, output, WIDTH, difference (A-B) mod 2^WIDTH.
REQ-010 SHALL have port Bout, output, 1, final borrow; 1 iff A < B unsigned.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 SHALL accept start only in IDLE or DONE: capture A and B into shift registers, clear borrow, clear bit counter, clear D, go to RUN.
REQ-013 SHALL in RUN process one bit per cycle, LSB first: diff = a0 ^ b0 ^ brw; brw_next = (~a0 & b0) | (~(a0 ^ b0) & brw).
REQ-014 SHALL shift each diff bit into D from the MSB end, so D is fully aligned after WIDTH bits.
REQ-015 SHALL shift both operand registers right one bit per RUN cycle.
REQ-016 SHALL leave RUN for DONE after exactly WIDTH RUN cycles; counter width is $clog2(WIDTH+1).
REQ-017 SHALL in DONE assert done for exactly one cycle, drive Bout with the final borrow, and return to IDLE unless start is high.
REQ-018 SHALL set latency so that start accepted on edge t gives done high in the cycle after edge t+WIDTH.
REQ-019 SHALL hold D and Bout stable from DONE until the next accepted start.
REQ-020 SHALL ignore start during RUN: no recapture and no effect on the result.
REQ-021 SHALL treat start in the DONE cycle as a back-to-back request: accept it, with done still pulsing in that cycle.
REQ-022 SHALL hold busy = 1 iff state is RUN; busy and done are never high together.
REQ-023 SHALL ignore A and B changes outside accepted start cycles.

Reset
REQ-024 SHALL on rst high at a clock edge force IDLE, with busy=0, done=0, D=0, Bout=0, borrow=0, counter=0.
REQ-025 SHALL on reset during RUN or DONE abort the operation with no done pulse; rst has priority over start.
REQ-026 SHALL not add any asynchronous reset path.

Structure
REQ-027 SHALL place FSM state encoding (2-bit IDLE=0, RUN=1, DONE=2) and DEFAULT_WIDTH=8 in a shared package, sub_pkg.
REQ-028 SHALL instantiate exactly one combinational sub-module, full_subtractor (ports X, Y, Bin, D, Bout), for the per-bit step; the borrow flip-flop and shift registers stay in serial_subtractor.

Verification
REQ-029 SHALL cover: WIDTH=8, A=100, B=37, start pulse -> busy high 8 cycles, done 9 cycles after start, D=63, Bout=0.
REQ-030 SHALL cover: A=0, B=1 -> D=0xFF, Bout=1; A=0x5A, B=0x5A -> D=0x00, Bout=0.
REQ-031 SHALL cover: start held high during RUN with A/B changed to 0xFF/0x00 -> result unchanged from the first request, done only once.
REQ-032 SHALL cover: rst asserted at RUN cycle 4 -> next cycle IDLE, all outputs 0, no done; a fresh start afterwards gives a correct result.
REQ-033 SHALL cover: start in the DONE cycle with A=200, B=55 -> first result valid with done pulse, busy high next cycle, second result D=145, Bout=0.
REQ-034 SHALL cover: a random sweep of 1000 operand pairs at WIDTH=8 and WIDTH=16 matching reference (A-B) mod 2^WIDTH and A<B.
